// File: rtl/ctrl_flow_pkg.sv
// Shared encodings for the call/return unit: opcodes, fault codes and FSM states.
package ctrl_flow_pkg;

  localparam logic [1:0] OP_CALL = 2'b01;
  localparam logic [1:0] OP_RET  = 2'b10;

  localparam logic [1:0] FLT_NONE = 2'b00;
  localparam logic [1:0] FLT_OVF  = 2'b01;
  localparam logic [1:0] FLT_UNF  = 2'b10;
  localparam logic [1:0] FLT_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/call_stack_mem.sv
// DEPTH x DATA_W return-address LIFO with occupancy count and optional circular overwrite.
module call_stack_mem #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 19,
  parameter bit WRAP   = 1'b0,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [DATA_W-1:0] rd_data_reg;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && (!full || WRAP);
  assign do_pop  = pop && !empty;

  // When full, ptr_reg points at the oldest entry, so a wrapping push overwrites it.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[ptr_reg] <= push_data;
    end
  end

  // Registered top-of-stack read; ptr_reg is stable for a cycle before the pop uses it.
  always_ff @(posedge clk) begin
    rd_data_reg <= mem[ptr_reg - PTR_W'(1)];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg   <= '0;
      count_reg <= '0;
    end else if (do_push) begin
      ptr_reg <= ptr_reg + PTR_W'(1);
      if (!full) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end else if (do_pop) begin
      ptr_reg   <= ptr_reg - PTR_W'(1);
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign rd_data = rd_data_reg;
  assign count   = count_reg;

endmodule

// File: rtl/call_ret_unit.sv
// Sequential CALL/RET unit with hardware return stack; build with CALL_STACK_WRAP_EN
// to make a CALL on a full stack overwrite the oldest entry instead of faulting.
module call_ret_unit
  import ctrl_flow_pkg::*;
#(
  parameter int PC_W    = 19,
  parameter int SP_W    = 8,
  parameter int DEPTH   = 16,
  parameter int SP_INIT = 255,
  localparam int DW     = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      op,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] addr,
  output logic            resp_valid,
  output logic [PC_W-1:0] new_pc,
  output logic [SP_W-1:0] new_sp,
  output logic [PC_W-1:0] stack_data,
  output logic            fault,
  output logic [1:0]      fault_code,
  output logic [DW-1:0]   depth
);

`ifdef CALL_STACK_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  state_t          state_reg;
  logic [1:0]      op_reg;
  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] addr_reg;
  logic            req_ready_reg;
  logic            resp_valid_reg;
  logic [PC_W-1:0] new_pc_reg;
  logic [SP_W-1:0] sp_reg;
  logic [PC_W-1:0] stack_data_reg;
  logic            fault_reg;
  logic [1:0]      fault_code_reg;

  logic [1:0]      flt_next;
  logic            stk_push;
  logic            stk_pop;
  logic [PC_W-1:0] ret_addr;
  logic [PC_W-1:0] stk_rd_data;
  logic [DW-1:0]   stk_count;
  logic            stk_full;
  logic            stk_empty;

  assign ret_addr = pc_reg + PC_W'(1);

  always_comb begin
    flt_next = FLT_NONE;
    if (op_reg == OP_CALL) begin
      if (stk_full && !WRAP_EN) begin
        flt_next = FLT_OVF;
      end
    end else if (op_reg == OP_RET) begin
      if (stk_empty) begin
        flt_next = FLT_UNF;
      end
    end else begin
      flt_next = FLT_ILL;
    end
  end

  assign stk_push = (state_reg == ST_BUSY) && (op_reg == OP_CALL) && (flt_next == FLT_NONE);
  assign stk_pop  = (state_reg == ST_BUSY) && (op_reg == OP_RET) && (flt_next == FLT_NONE);

  call_stack_mem #(
    .DEPTH (DEPTH),
    .DATA_W(PC_W),
    .WRAP  (WRAP_EN)
  ) u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (stk_push),
    .pop      (stk_pop),
    .push_data(ret_addr),
    .rd_data  (stk_rd_data),
    .count    (stk_count),
    .full     (stk_full),
    .empty    (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      op_reg         <= 2'b00;
      pc_reg         <= '0;
      addr_reg       <= '0;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
      new_pc_reg     <= '0;
      sp_reg         <= SP_W'(SP_INIT);
      stack_data_reg <= '0;
      fault_reg      <= 1'b0;
      fault_code_reg <= FLT_NONE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          resp_valid_reg <= 1'b0;
          if (req_valid) begin
            op_reg        <= op;
            pc_reg        <= pc;
            addr_reg      <= addr;
            req_ready_reg <= 1'b0;
            state_reg     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          resp_valid_reg <= 1'b1;
          fault_code_reg <= flt_next;
          state_reg      <= ST_RESP;
          if (flt_next != FLT_NONE) begin
            new_pc_reg     <= pc_reg;
            stack_data_reg <= '0;
            fault_reg      <= 1'b1;
          end else if (op_reg == OP_CALL) begin
            new_pc_reg     <= addr_reg;
            stack_data_reg <= ret_addr;
            sp_reg         <= sp_reg - SP_W'(1);
            fault_reg      <= 1'b0;
          end else begin
            new_pc_reg     <= stk_rd_data;
            stack_data_reg <= stk_rd_data;
            sp_reg         <= sp_reg + SP_W'(1);
            fault_reg      <= 1'b0;
          end
        end
        ST_RESP: begin
          resp_valid_reg <= 1'b0;
          req_ready_reg  <= 1'b1;
          state_reg      <= ST_IDLE;
        end
        default: begin
          resp_valid_reg <= 1'b0;
          req_ready_reg  <= 1'b1;
          state_reg      <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_reg;
  assign resp_valid = resp_valid_reg;
  assign new_pc     = new_pc_reg;
  assign new_sp     = sp_reg;
  assign stack_data = stack_data_reg;
  assign fault      = fault_reg;
  assign fault_code = fault_code_reg;
  assign depth      = stk_count;

endmodule

// File: tb/tb_call_ret_unit.sv
// Directed scoreboard bench for call_ret_unit; honours CALL_STACK_WRAP_EN like the design.
module tb_call_ret_unit;

  localparam int PC_W  = 19;
  localparam int SP_W  = 8;
  localparam int DEPTH = 16;
  localparam int DW    = $clog2(DEPTH) + 1;

`ifdef CALL_STACK_WRAP_EN
  localparam bit M_WRAP = 1'b1;
`else
  localparam bit M_WRAP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      op;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] addr;
  logic            resp_valid;
  logic [PC_W-1:0] new_pc;
  logic [SP_W-1:0] new_sp;
  logic [PC_W-1:0] stack_data;
  logic            fault;
  logic [1:0]      fault_code;
  logic [DW-1:0]   depth;

  call_ret_unit #(
    .PC_W(PC_W), .SP_W(SP_W), .DEPTH(DEPTH), .SP_INIT(255)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .pc(pc), .addr(addr), .resp_valid(resp_valid), .new_pc(new_pc),
    .new_sp(new_sp), .stack_data(stack_data), .fault(fault),
    .fault_code(fault_code), .depth(depth)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0] new_pc;
    logic [SP_W-1:0] new_sp;
    logic [PC_W-1:0] stack_data;
    logic            fault;
    logic [1:0]      code;
    logic [DW-1:0]   depth;
  } exp_t;

  exp_t            sb[$];
  logic [PC_W-1:0] m_stk[$];
  logic [SP_W-1:0] m_sp;
  int              n_cmp = 0;
  int              n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one operation, applied to the bench's own stack model.
  task automatic model(input logic [1:0] o, input logic [PC_W-1:0] p,
                       input logic [PC_W-1:0] a, output exp_t e);
    logic [PC_W-1:0] r;
    e.new_pc     = p;
    e.stack_data = '0;
    e.fault      = 1'b1;
    e.code       = 2'b11;
    if (o == 2'b01) begin
      if (m_stk.size() < DEPTH || M_WRAP) begin
        if (m_stk.size() == DEPTH) void'(m_stk.pop_front());
        r = p + 19'd1;
        m_stk.push_back(r);
        e.new_pc     = a;
        e.stack_data = r;
        m_sp         = m_sp - 8'd1;
        e.fault      = 1'b0;
        e.code       = 2'b00;
      end else begin
        e.code = 2'b01;
      end
    end else if (o == 2'b10) begin
      if (m_stk.size() > 0) begin
        r            = m_stk.pop_back();
        e.new_pc     = r;
        e.stack_data = r;
        m_sp         = m_sp + 8'd1;
        e.fault      = 1'b0;
        e.code       = 2'b00;
      end else begin
        e.code = 2'b10;
      end
    end
    e.new_sp = m_sp;
    e.depth  = DW'(m_stk.size());
  endtask

  task automatic chk_resp();
    exp_t e;
    chk("resp_valid", 32'(resp_valid), 32'd1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("new_pc", 32'(new_pc), 32'(e.new_pc));
      chk("new_sp", 32'(new_sp), 32'(e.new_sp));
      chk("stack_data", 32'(stack_data), 32'(e.stack_data));
      chk("fault", 32'(fault), 32'(e.fault));
      chk("fault_code", 32'(fault_code), 32'(e.code));
      chk("depth", 32'(depth), 32'(e.depth));
      $display("resp op done: new_pc=%0d new_sp=%0d stack_data=%0d fault=%0d code=%0d depth=%0d",
               new_pc, new_sp, stack_data, fault, fault_code, depth);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [PC_W-1:0] p, input logic [PC_W-1:0] a);
    exp_t e;
    model(o, p, a, e);
    sb.push_back(e);
    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; op = o; pc = p; addr = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("busy_no_resp", 32'(resp_valid), 32'd0);
    chk("busy_not_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk_resp();
    @(posedge clk); #1;
    chk("resp_drop", 32'(resp_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_stk.delete();
    m_sp = 8'd255;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts;
    int resps;
    req_valid = 1'b0; op = 2'b00; pc = '0; addr = '0;
    m_sp = 8'd255;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_new_pc", 32'(new_pc), 32'd0);
    chk("rst_new_sp", 32'(new_sp), 32'd255);
    chk("rst_stack_data", 32'(stack_data), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_fault_code", 32'(fault_code), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    rst_n = 1'b1;

    // Underflow from reset, then nested CALL/CALL/RET/RET.
    issue(2'b10, 19'd77, 19'd0);
    issue(2'b01, 19'd50, 19'd150);
    issue(2'b01, 19'd160, 19'd300);
    issue(2'b10, 19'd0, 19'd0);
    issue(2'b10, 19'd0, 19'd0);

    // Illegal opcodes leave state alone, with a live entry on the stack.
    issue(2'b01, 19'd10, 19'd20);
    issue(2'b11, 19'd33, 19'd44);
    issue(2'b00, 19'd34, 19'd45);
    issue(2'b10, 19'd0, 19'd0);

    // Back-to-back requests: one accept every three cycles.
    accepts = 0; resps = 0;
    req_valid = 1'b1; op = 2'b11; pc = 19'd7; addr = 19'd0;
    for (int i = 0; i < 9; i++) begin
      exp_t e;
      @(negedge clk);
      if (resp_valid) begin
        resps++;
        chk_resp();
      end
      if (req_ready) begin
        accepts++;
        model(2'b11, 19'd7, 19'd0, e);
        sb.push_back(e);
      end
      if (i == 8) req_valid = 1'b0;
    end
    chk("tput_accepts", 32'(accepts), 32'd3);
    chk("tput_resps", 32'(resps), 32'd3);
    @(posedge clk); #1;

    // Reset asserted while BUSY discards the op.
    issue(2'b01, 19'd100, 19'd200);
    @(negedge clk);
    req_valid = 1'b1; op = 2'b01; pc = 19'd500; addr = 19'd600;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_stk.delete();
    m_sp = 8'd255;
    chk("midrst_no_resp", 32'(resp_valid), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_depth", 32'(depth), 32'd0);
    chk("midrst_sp", 32'(new_sp), 32'd255);
    @(posedge clk); #1;
    chk("midrst_still_no_resp", 32'(resp_valid), 32'd0);

    // Return-address wrap at the top of the PC range.
    issue(2'b01, 19'h7FFFF, 19'd5);
    issue(2'b10, 19'd0, 19'd0);

    // DEPTH+1 CALLs then DEPTH+1 RETs exercise overflow (or overwrite) and underflow.
    do_reset();
    for (int i = 0; i <= DEPTH; i++) issue(2'b01, 19'(i * 10 + 3), 19'(1000 + i));
    for (int i = 0; i <= DEPTH; i++) issue(2'b10, 19'(i), 19'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
